// File: rtl/fetch_pkg.sv
// Shared fetch-path types: fetch_entry_t is the payload carried from Fetch
// through the fetch queue into the Decode input latch.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_WIDTH  = 32;
  localparam int unsigned FETCH_INSTR_WIDTH = 32;

  // One fetched instruction plus the prediction made for it at fetch.
  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0]  pc;
    logic [FETCH_INSTR_WIDTH-1:0] instr;
    logic                         pred_taken;
    logic [FETCH_ADDR_WIDTH-1:0]  pred_target;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Dual-issue instruction buffer between Fetch and Decode.
// Accepts up to two instructions per cycle (slot 0 older than slot 1) and
// presents the two oldest entries to Decode, which may pop 0, 1 or 2 per cycle
// in program order. A flush discards every entry.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               discard all entries; overrides same-cycle enq/deq
//   enq_*_0 / enq_*_1   enqueue slots (valid, pc, instr, pred_taken, pred_target)
//   enq_ready           room for two entries (from registered count only)
//   deq_*_0 / deq_*_1   head / head+1 entry and its valid flag
//   deq_ready_0/1       Decode consumes head / head+1
//   count               current occupancy
// ADDR_WIDTH / INSTR_WIDTH must match the widths of fetch_pkg::fetch_entry_t.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = FETCH_ADDR_WIDTH,
  parameter int unsigned INSTR_WIDTH = FETCH_INSTR_WIDTH,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned PTR_WIDTH   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   enq_valid_0,
  input  logic [ADDR_WIDTH-1:0]  enq_pc_0,
  input  logic [INSTR_WIDTH-1:0] enq_instr_0,
  input  logic                   enq_pred_taken_0,
  input  logic [ADDR_WIDTH-1:0]  enq_pred_target_0,
  input  logic                   enq_valid_1,
  input  logic [ADDR_WIDTH-1:0]  enq_pc_1,
  input  logic [INSTR_WIDTH-1:0] enq_instr_1,
  input  logic                   enq_pred_taken_1,
  input  logic [ADDR_WIDTH-1:0]  enq_pred_target_1,
  output logic                   enq_ready,
  output logic                   deq_valid_0,
  output logic [ADDR_WIDTH-1:0]  deq_pc_0,
  output logic [INSTR_WIDTH-1:0] deq_instr_0,
  output logic                   deq_pred_taken_0,
  output logic [ADDR_WIDTH-1:0]  deq_pred_target_0,
  output logic                   deq_valid_1,
  output logic [ADDR_WIDTH-1:0]  deq_pc_1,
  output logic [INSTR_WIDTH-1:0] deq_instr_1,
  output logic                   deq_pred_taken_1,
  output logic [ADDR_WIDTH-1:0]  deq_pred_target_1,
  input  logic                   deq_ready_0,
  input  logic                   deq_ready_1,
  output logic [PTR_WIDTH:0]     count
);

  localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;
  // Highest occupancy at which a full pair still fits.
  localparam logic [CNT_WIDTH-1:0] ENQ_LIMIT = CNT_WIDTH'(DEPTH - 2);

  fetch_entry_t           mem [DEPTH];
  logic [PTR_WIDTH-1:0]   head;
  logic [PTR_WIDTH-1:0]   tail;
  logic [PTR_WIDTH-1:0]   head_1;
  logic [PTR_WIDTH-1:0]   tail_1;
  logic                   enq0;
  logic                   enq1;
  logic                   deq0;
  logic                   deq1;
  logic [CNT_WIDTH-1:0]   count_next;
  fetch_entry_t           enq_entry_0;
  fetch_entry_t           enq_entry_1;
  fetch_entry_t           head_entry_0;
  fetch_entry_t           head_entry_1;

  // Pointer neighbours; DEPTH is a power of two so the add wraps naturally.
  assign head_1 = head + PTR_WIDTH'(1);
  assign tail_1 = tail + PTR_WIDTH'(1);

  // No credit for a same-cycle dequeue: ready depends on registered count only.
  assign enq_ready = (count <= ENQ_LIMIT);

  assign deq_valid_0 = (count != '0);
  assign deq_valid_1 = (count >= CNT_WIDTH'(2));

  // Fire qualifiers; slot 1 only moves together with slot 0 to keep order.
  assign enq0 = enq_valid_0 & enq_ready & ~flush;
  assign enq1 = enq0 & enq_valid_1;
  assign deq0 = deq_valid_0 & deq_ready_0 & ~flush;
  assign deq1 = deq0 & deq_valid_1 & deq_ready_1;

  assign count_next = count + CNT_WIDTH'(enq0) + CNT_WIDTH'(enq1)
                            - CNT_WIDTH'(deq0) - CNT_WIDTH'(deq1);

  assign enq_entry_0 = '{pc: enq_pc_0, instr: enq_instr_0,
                         pred_taken: enq_pred_taken_0,
                         pred_target: enq_pred_target_0};
  assign enq_entry_1 = '{pc: enq_pc_1, instr: enq_instr_1,
                         pred_taken: enq_pred_taken_1,
                         pred_target: enq_pred_target_1};

  // Head pair read straight from storage; new entries appear the cycle after.
  assign head_entry_0 = mem[head];
  assign head_entry_1 = mem[head_1];

  assign deq_pc_0          = head_entry_0.pc;
  assign deq_instr_0       = head_entry_0.instr;
  assign deq_pred_taken_0  = head_entry_0.pred_taken;
  assign deq_pred_target_0 = head_entry_0.pred_target;
  assign deq_pc_1          = head_entry_1.pc;
  assign deq_instr_1       = head_entry_1.instr;
  assign deq_pred_taken_1  = head_entry_1.pred_taken;
  assign deq_pred_target_1 = head_entry_1.pred_target;

  // Pointer and occupancy state; flush empties the queue outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_WIDTH'(deq0) + PTR_WIDTH'(deq1);
      tail  <= tail + PTR_WIDTH'(enq0) + PTR_WIDTH'(enq1);
      count <= count_next;
    end
  end

  // Entry storage; cleared on reset so idle outputs read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (enq0) begin
        mem[tail] <= enq_entry_0;
      end
      if (enq1) begin
        mem[tail_1] <= enq_entry_1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset state, pair enqueue, fill to full,
// streaming across the pointer wrap, mixed enq/deq, flush and async reset.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        enq_valid_0, enq_valid_1;
  logic [31:0] enq_pc_0, enq_pc_1, enq_instr_0, enq_instr_1;
  logic        enq_pred_taken_0, enq_pred_taken_1;
  logic [31:0] enq_pred_target_0, enq_pred_target_1;
  logic        enq_ready;
  logic        deq_valid_0, deq_valid_1;
  logic [31:0] deq_pc_0, deq_pc_1, deq_instr_0, deq_instr_1;
  logic        deq_pred_taken_0, deq_pred_taken_1;
  logic [31:0] deq_pred_target_0, deq_pred_target_1;
  logic        deq_ready_0, deq_ready_1;
  logic [3:0]  count;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid_0(enq_valid_0), .enq_pc_0(enq_pc_0), .enq_instr_0(enq_instr_0),
    .enq_pred_taken_0(enq_pred_taken_0), .enq_pred_target_0(enq_pred_target_0),
    .enq_valid_1(enq_valid_1), .enq_pc_1(enq_pc_1), .enq_instr_1(enq_instr_1),
    .enq_pred_taken_1(enq_pred_taken_1), .enq_pred_target_1(enq_pred_target_1),
    .enq_ready(enq_ready),
    .deq_valid_0(deq_valid_0), .deq_pc_0(deq_pc_0), .deq_instr_0(deq_instr_0),
    .deq_pred_taken_0(deq_pred_taken_0), .deq_pred_target_0(deq_pred_target_0),
    .deq_valid_1(deq_valid_1), .deq_pc_1(deq_pc_1), .deq_instr_1(deq_instr_1),
    .deq_pred_taken_1(deq_pred_taken_1), .deq_pred_target_1(deq_pred_target_1),
    .deq_ready_0(deq_ready_0), .deq_ready_1(deq_ready_1),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  fetch_entry_t exp_q[$];
  logic         last_enq;
  logic [31:0]  nxt;
  logic [31:0]  exp_pc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic fetch_entry_t mk(input logic [31:0] pc);
    mk = '{pc: pc, instr: {pc[15:0], 16'h0093}, pred_taken: pc[3],
           pred_target: pc + 32'h80};
  endfunction

  task automatic idle();
    flush = 1'b0; enq_valid_0 = 1'b0; enq_valid_1 = 1'b0;
    deq_ready_0 = 1'b0; deq_ready_1 = 1'b0;
  endtask

  // Compare visible DUT state against the reference queue.
  task automatic check_state(input string tag);
    int sz = exp_q.size();
    chk({tag, ".count"}, 64'(count), 64'(sz));
    chk({tag, ".deq_valid_0"}, 64'(deq_valid_0), 64'(sz >= 1));
    chk({tag, ".deq_valid_1"}, 64'(deq_valid_1), 64'(sz >= 2));
    chk({tag, ".enq_ready"}, 64'(enq_ready), 64'(sz <= DEPTH - 2));
    if (sz >= 1) begin
      chk({tag, ".head0"}, {deq_pc_0, deq_instr_0},
          {exp_q[0].pc, exp_q[0].instr});
      chk({tag, ".pred0"}, {31'd0, deq_pred_taken_0, deq_pred_target_0},
          {31'd0, exp_q[0].pred_taken, exp_q[0].pred_target});
    end
    if (sz >= 2) begin
      chk({tag, ".head1"}, {deq_pc_1, deq_instr_1},
          {exp_q[1].pc, exp_q[1].instr});
      chk({tag, ".pred1"}, {31'd0, deq_pred_taken_1, deq_pred_target_1},
          {31'd0, exp_q[1].pred_taken, exp_q[1].pred_target});
    end
  endtask

  // One clock: drive, update the reference queue, check, return to idle.
  task automatic cycle(input string tag, input fetch_entry_t a, input fetch_entry_t b,
                       input logic v0, input logic v1, input logic r0,
                       input logic r1, input logic fl);
    int   sz = exp_q.size();
    logic rdy = (sz <= DEPTH - 2);
    logic e0  = v0 && rdy && !fl;
    logic e1  = e0 && v1;
    logic d0  = (sz >= 1) && r0 && !fl;
    logic d1  = d0 && (sz >= 2) && r1;
    enq_valid_0 = v0; enq_pc_0 = a.pc; enq_instr_0 = a.instr;
    enq_pred_taken_0 = a.pred_taken; enq_pred_target_0 = a.pred_target;
    enq_valid_1 = v1; enq_pc_1 = b.pc; enq_instr_1 = b.instr;
    enq_pred_taken_1 = b.pred_taken; enq_pred_target_1 = b.pred_target;
    deq_ready_0 = r0; deq_ready_1 = r1; flush = fl;
    @(posedge clk);
    #1;
    if (fl) exp_q.delete();
    else begin
      if (d0) void'(exp_q.pop_front());
      if (d1) void'(exp_q.pop_front());
      if (e0) exp_q.push_back(a);
      if (e1) exp_q.push_back(b);
    end
    last_enq = e0;
    check_state(tag);
    idle();
  endtask

  // Enqueue the next sequential PC pair with the given pops.
  task automatic stream(input string tag, input logic r0, input logic r1, input logic fl);
    cycle(tag, mk(nxt), mk(nxt + 32'd4), 1'b1, 1'b1, r0, r1, fl);
    if (last_enq) nxt = nxt + 32'd8;
  endtask

  initial begin
    fetch_entry_t p0, p1;
    idle();
    enq_pc_0 = '0; enq_instr_0 = '0; enq_pred_taken_0 = 1'b0; enq_pred_target_0 = '0;
    enq_pc_1 = '0; enq_instr_1 = '0; enq_pred_taken_1 = 1'b0; enq_pred_target_1 = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.deq_valid_0", 64'(deq_valid_0), 64'd0);
    chk("reset.deq_valid_1", 64'(deq_valid_1), 64'd0);
    chk("reset.enq_ready", 64'(enq_ready), 64'd1);
    chk("reset.count", 64'(count), 64'd0);
    chk("reset.deq_pc_0", 64'(deq_pc_0), 64'd0);
    rst = 1'b0;

    // First pair with explicit fields.
    p0 = '{pc: 32'h100, instr: 32'h0000_0013, pred_taken: 1'b0, pred_target: 32'h0};
    p1 = '{pc: 32'h104, instr: 32'h0010_0093, pred_taken: 1'b1, pred_target: 32'h200};
    cycle("pair", p0, p1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pair.count", 64'(count), 64'd2);
    chk("pair.pc0", 64'(deq_pc_0), 64'h100);
    chk("pair.pc1", 64'(deq_pc_1), 64'h104);
    chk("pair.instr1", 64'(deq_instr_1), 64'h0010_0093);
    chk("pair.taken1", 64'(deq_pred_taken_1), 64'd1);
    chk("pair.target1", 64'(deq_pred_target_1), 64'h200);

    // Fill to full, then hold enq_valid while full.
    nxt = 32'h108;
    stream("fill2", 1'b0, 1'b0, 1'b0);
    stream("fill3", 1'b0, 1'b0, 1'b0);
    chk("fill6.count", 64'(count), 64'd6);
    chk("fill6.enq_ready", 64'(enq_ready), 64'd1);
    stream("fill4", 1'b0, 1'b0, 1'b0);
    chk("full.count", 64'(count), 64'd8);
    chk("full.enq_ready", 64'(enq_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      stream("fullhold", 1'b0, 1'b0, 1'b0);
      chk("fullhold.count", 64'(count), 64'd8);
      chk("fullhold.pc0", 64'(deq_pc_0), 64'h100);
    end

    // Pop two per cycle while offering two: blocked once at full, then steady.
    for (int i = 0; i < 5; i++) begin
      stream("stream", 1'b1, 1'b1, 1'b0);
      chk("stream.count", 64'(count), 64'd6);
    end

    // Single pop to 5, then pair enqueue with single pop back to 6.
    cycle("pop1", mk(32'h0), mk(32'h0), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pop1.count", 64'(count), 64'd5);
    exp_pc = exp_q[1].pc;
    stream("mix", 1'b1, 1'b0, 1'b0);
    chk("mix.count", 64'(count), 64'd6);
    chk("mix.newhead", 64'(deq_pc_0), 64'(exp_pc));

    // Odd head alignment so a pair straddles index 7 -> 0.
    stream("skew", 1'b1, 1'b0, 1'b0);
    stream("wrap_a", 1'b1, 1'b1, 1'b0);
    stream("wrap_b", 1'b1, 1'b1, 1'b0);
    stream("refill", 1'b1, 1'b0, 1'b0);
    chk("preflush.count", 64'(count), 64'd6);

    // Flush beats same-cycle enqueue and dequeue.
    stream("flush", 1'b1, 1'b1, 1'b1);
    chk("flush.count", 64'(count), 64'd0);
    chk("flush.deq_valid_0", 64'(deq_valid_0), 64'd0);
    nxt = 32'h500;
    stream("postflush", 1'b0, 1'b0, 1'b0);
    chk("postflush.pc0", 64'(deq_pc_0), 64'h500);
    chk("postflush.pc1", 64'(deq_pc_1), 64'h504);
    stream("build4", 1'b0, 1'b0, 1'b0);
    chk("build4.count", 64'(count), 64'd4);

    // Asynchronous reset away from any clock edge.
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst.count", 64'(count), 64'd0);
    chk("async_rst.deq_valid_0", 64'(deq_valid_0), 64'd0);
    chk("async_rst.deq_valid_1", 64'(deq_valid_1), 64'd0);
    chk("async_rst.enq_ready", 64'(enq_ready), 64'd1);
    chk("async_rst.deq_pc_0", 64'(deq_pc_0), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    nxt = 32'h700;
    stream("after_rst", 1'b0, 1'b0, 1'b0);
    chk("after_rst.pc0", 64'(deq_pc_0), 64'h700);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Dual-issue instruction buffer between the Fetch stage and Decode.
- Each cycle it accepts up to two fetched instructions, each tagged with the branch prediction made for it at fetch (taken flag and target from the branch target buffer).
- Decode removes up to two entries per cycle, in program order.
- Flushed on a redirect from Commit or Execute.

Parameters:
- ADDR_WIDTH, 32, PC and target width.
- INSTR_WIDTH, 32, instruction word width.
- DEPTH, 8, number of entries; must be a power of two and ≥ 4.
- PTR_WIDTH, $clog2(DEPTH), head/tail pointer width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  discard all entries (branch mispredict / exception redirect)
- enq_valid_0  in  1  slot 0 enqueue request
- enq_pc_0  in  ADDR_WIDTH  PC of slot 0
- enq_instr_0  in  INSTR_WIDTH  instruction of slot 0
- enq_pred_taken_0  in  1  predicted taken for slot 0
- enq_pred_target_0  in  ADDR_WIDTH  predicted next PC for slot 0
- enq_valid_1 / enq_pc_1 / enq_instr_1 / enq_pred_taken_1 / enq_pred_target_1  in  as slot 0  slot 1 (younger)
- enq_ready  out  1  both slots can be accepted this cycle
- deq_valid_0 / deq_valid_1  out  1  entry at head / head+1 present
- deq_pc_0/1, deq_instr_0/1, deq_pred_taken_0/1, deq_pred_target_0/1  out  as enq  head / head+1 entry fields
- deq_ready_0 / deq_ready_1  in  1  Decode consumes head / head+1
- count  out  PTR_WIDTH+1  current occupancy

Behaviour:
- State: DEPTH-entry circular array, head, tail (PTR_WIDTH bits, wrap modulo DEPTH), count (0..DEPTH).
- Reset (async): head=tail=count=0; all entries cleared to zero.
  - deq_valid_0/1=0, enq_ready=1, count=0.
  - deq data outputs read 0 after reset.
- enq_ready = (DEPTH - count) ≥ 2, combinational from registered count only.
  - No credit is given for a dequeue in the same cycle.
- Enqueue fire:
  - enq0 = enq_valid_0 & enq_ready & !flush.
  - enq1 = enq0 & enq_valid_1.
  - enq_valid_1 without enq_valid_0 is ignored.
  - enq0 writes array[tail]; enq1 writes array[tail+1] (wrapped).
  - tail advances by enq0+enq1.
- Dequeue outputs are combinational from registered state; no bypass, so an entry enqueued in cycle N is first visible in cycle N+1.
  - deq_valid_0 = count ≥ 1; deq_valid_1 = count ≥ 2.
  - Slot 0 reads array[head]; slot 1 reads array[head+1] (wrapped).
- Dequeue fire:
  - deq0 = deq_valid_0 & deq_ready_0 & !flush.
  - deq1 = deq0 & deq_valid_1 & deq_ready_1.
  - deq_ready_1 without deq_ready_0 pops nothing.
  - head advances by deq0+deq1.
- count_next = count + (enq0+enq1) - (deq0+deq1). Simultaneous enqueue and dequeue are both applied.
- Flush has priority over everything: at the next edge head=tail=count=0, and same-cycle enq/deq have no effect. Array contents need not be cleared.
- Full (count=DEPTH) or count=DEPTH-1: enq_ready=0.
- Empty: deq_valid_0=0, and deq_ready inputs are ignored.
- Pointer wrap: entries at index DEPTH-1 and 0 form a legal pair for both enqueue and dequeue.
- Program order is preserved: slot 0 is always older than slot 1, on both enqueue and dequeue.

Decomposition:
- Shared fetch_pkg holds fetch_entry_t (packed: pc, instr, pred_taken, pred_target).
- Decode later reuses fetch_entry_t for its input latch.
- No sub-module: storage is a plain array of fetch_entry_t inside fetch_queue.

Test Plan:
- Reset then idle → deq_valid_0=0, deq_valid_1=0, enq_ready=1, count=0.
- Enqueue pair PC 0x100/0x104 (instr 0x00000013, 0x00100093; slot 1 pred_taken=1, target 0x200), deq_ready low → next cycle count=2, deq_pc_0=0x100, deq_pc_1=0x104, deq_pred_taken_1=1, deq_pred_target_1=0x200.
- Fill with 3 pairs (count=6): enq_ready=1. One more pair → count=8, enq_ready=0. Further enq_valid for 3 cycles → count stays 8, contents unchanged.
- From count=8, pop 2 per cycle while enqueueing 2 → count stays at 6 after first pop, then holds 6. PC order crosses the index 7→0 wrap with no gaps or duplicates.
- count=5, simultaneous enqueue pair + single pop (deq_ready_0=1, deq_ready_1=0) → count=6, new head is the former head+1.
- count=6, flush asserted together with enq_valid_0/1 and deq_ready_0/1 → next cycle count=0, deq_valid_0=0. Following pair enqueue appears at the head.
- rst asserted mid-run at count=4 → outputs go to reset values immediately, without waiting for a clock edge.
